// File: rtl/uart_fifo_if.sv
// UART with TX/RX FIFOs, configurable framing, CTS/RTS flow control and sticky errors.
// Byte side uses a WE/RE FIFO handshake; the RX FIFO head is first-word fall-through.
module uart_fifo_if #(
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 WE_I,
  input  logic [DATA_BITS-1:0] DSEND_I,
  output logic                 TX_FULL_O,
  output logic                 TX_BUSY_O,
  input  logic                 RE_I,
  output logic [DATA_BITS-1:0] DREC_O,
  output logic                 RX_EMPTY_O,
  output logic                 RX_FULL_O,
  input  logic                 RX_I,
  output logic                 TX_O,
  input  logic                 CTS_I,
  output logic                 RTS_O,
  output logic                 FRAME_ERR_O,
  output logic                 PARITY_ERR_O,
  output logic                 OVERRUN_O,
  input  logic                 ERR_CLR_I
);

  localparam int DIV  = CLK_RATE / BAUD_RATE;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam int CW   = $clog2(STOP_BITS * DIV);

  localparam logic [NW-1:0] DEPTH_C  = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] HALF_C   = NW'(FIFO_DEPTH / 2);
  localparam logic [CW-1:0] BIT_C    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALFB_C  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOPB_C  = CW'(STOP_BITS * DIV - 1);
  localparam logic [3:0]    LAST_C   = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr_q, tx_rd_q;
  logic [NW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                 tx_full_q;
  logic                 tx_push, tx_pop;

  assign tx_push = WE_I && (tx_cnt_q != DEPTH_C);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + NW'(1);
    else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - NW'(1);
  end

  // NOTE: FIFO storage has no reset; only pointers and counts define validity.
  always_ff @(posedge CLK_I) begin
    if (tx_push) tx_mem[tx_wr_q] <= DSEND_I;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      tx_full_q <= 1'b0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      tx_cnt_q  <= tx_cnt_d;
      tx_full_q <= (tx_cnt_d == DEPTH_C);
    end
  end

  // ---------------- TX FSM ----------------
  state_e               tx_state_q;
  logic [CW-1:0]        tx_baud_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q, tx_q;
  logic                 tx_last;

  assign tx_last = (tx_baud_q == '0);
  // A new frame starts from IDLE or straight out of the final stop cycle.
  assign tx_pop  = (tx_cnt_q != '0) && CTS_I &&
                   ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && tx_last));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= S_START;
      tx_baud_q  <= BIT_C;
      tx_sh_q    <= tx_mem[tx_rd_q];
      tx_par_q   <= par_bit(tx_mem[tx_rd_q]);
      tx_q       <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: tx_q <= 1'b1;
        S_START: begin
          if (tx_last) begin
            tx_state_q <= S_DATA;
            tx_baud_q  <= BIT_C;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
          end else tx_baud_q <= tx_baud_q - CW'(1);
        end
        S_DATA: begin
          if (tx_last) begin
            if (tx_bit_q == LAST_C) begin
              if (PARITY != 0) begin
                tx_state_q <= S_PARITY;
                tx_baud_q  <= BIT_C;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_baud_q  <= STOPB_C;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q  <= tx_bit_q + 4'd1;
              tx_sh_q   <= tx_sh_q >> 1;
              tx_baud_q <= BIT_C;
              tx_q      <= tx_sh_q[1];
            end
          end else tx_baud_q <= tx_baud_q - CW'(1);
        end
        S_PARITY: begin
          if (tx_last) begin
            tx_state_q <= S_STOP;
            tx_baud_q  <= STOPB_C;
            tx_q       <= 1'b1;
          end else tx_baud_q <= tx_baud_q - CW'(1);
        end
        S_STOP: begin
          if (tx_last) begin
            tx_state_q <= S_IDLE;
            tx_q       <= 1'b1;
          end else tx_baud_q <= tx_baud_q - CW'(1);
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_e               rx_state_q;
  logic [CW-1:0]        rx_baud_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_par_q;
  logic                 rx_last, rx_stop_evt, rx_par_ok;

  assign rx_last     = (rx_baud_q == '0);
  assign rx_stop_evt = (rx_state_q == S_STOP) && rx_last;
  assign rx_par_ok   = (PARITY == 0) || ((^{rx_sh_q, rx_par_q}) == (PARITY == 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_meta_q <= RX_I;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= S_START;
            rx_baud_q  <= HALFB_C;
          end
        end
        S_START: begin
          if (rx_last) begin
            // A start bit that is high again at its centre was a glitch.
            rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
            rx_baud_q  <= BIT_C;
            rx_bit_q   <= '0;
          end else rx_baud_q <= rx_baud_q - CW'(1);
        end
        S_DATA: begin
          if (rx_last) begin
            rx_sh_q   <= {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
            rx_baud_q <= BIT_C;
            if (rx_bit_q == LAST_C) rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                    rx_bit_q   <= rx_bit_q + 4'd1;
          end else rx_baud_q <= rx_baud_q - CW'(1);
        end
        S_PARITY: begin
          if (rx_last) begin
            rx_par_q   <= rx_sync_q;
            rx_state_q <= S_STOP;
            rx_baud_q  <= BIT_C;
          end else rx_baud_q <= rx_baud_q - CW'(1);
        end
        S_STOP: begin
          if (rx_last) rx_state_q <= S_IDLE;
          else         rx_baud_q  <= rx_baud_q - CW'(1);
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and status ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr_q, rx_rd_q;
  logic [NW-1:0]        rx_cnt_q, rx_cnt_d;
  logic                 rx_empty_q, rx_full_q, rts_q;
  logic                 frame_err_q, parity_err_q, overrun_q;
  logic                 rx_good, rx_pop, rx_push;

  assign rx_good = rx_stop_evt && rx_sync_q && rx_par_ok;
  assign rx_pop  = RE_I && (rx_cnt_q != '0);
  // When full, a simultaneous pop frees the slot the new byte needs.
  assign rx_push = rx_good && ((rx_cnt_q != DEPTH_C) || rx_pop);

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + NW'(1);
    else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - NW'(1);
  end

  always_ff @(posedge CLK_I) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
      rx_empty_q   <= 1'b1;
      rx_full_q    <= 1'b0;
      rts_q        <= 1'b1;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      rx_cnt_q     <= rx_cnt_d;
      rx_empty_q   <= (rx_cnt_d == '0);
      rx_full_q    <= (rx_cnt_d == DEPTH_C);
      rts_q        <= (rx_cnt_d < HALF_C);
      frame_err_q  <= (rx_stop_evt && !rx_sync_q) || (frame_err_q && !ERR_CLR_I);
      parity_err_q <= (rx_stop_evt && rx_sync_q && !rx_par_ok) || (parity_err_q && !ERR_CLR_I);
      overrun_q    <= (rx_good && !rx_push) || (overrun_q && !ERR_CLR_I);
    end
  end

  assign TX_O         = tx_q;
  assign TX_FULL_O    = tx_full_q;
  assign TX_BUSY_O    = (tx_cnt_q != '0) || (tx_state_q != S_IDLE);
  assign DREC_O       = rx_empty_q ? '0 : rx_mem[rx_rd_q];
  assign RX_EMPTY_O   = rx_empty_q;
  assign RX_FULL_O    = rx_full_q;
  assign RTS_O        = rts_q;
  assign FRAME_ERR_O  = frame_err_q;
  assign PARITY_ERR_O = parity_err_q;
  assign OVERRUN_O    = overrun_q;

endmodule

// File: tb/tb_uart_fifo_if.sv
// Directed bench: 8N1/depth-4 instance (dut0) and 7E2/depth-4 instance (dut1), DIV = 16.
module tb_uart_fifo_if;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic       we0 = 0, re0 = 0, cts0 = 1, clr0 = 0, rx0_drv = 1, loop0 = 0;
  logic [7:0] ds0 = '0, drec0;
  logic       tx0, txfull0, busy0, empty0, rxfull0, rts0, ferr0, perr0, ovr0, rx0_in;
  logic       we1 = 0, re1 = 0, cts1 = 1, clr1 = 0, rx1_drv = 1, loop1 = 0;
  logic [6:0] ds1 = '0, drec1;
  logic       tx1, txfull1, busy1, empty1, rxfull1, rts1, ferr1, perr1, ovr1, rx1_in;

  assign rx0_in = loop0 ? tx0 : rx0_drv;
  assign rx1_in = loop1 ? tx1 : rx1_drv;

  uart_fifo_if #(.CLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .CLK_I(clk), .RST_I(rst), .WE_I(we0), .DSEND_I(ds0), .TX_FULL_O(txfull0),
    .TX_BUSY_O(busy0), .RE_I(re0), .DREC_O(drec0), .RX_EMPTY_O(empty0),
    .RX_FULL_O(rxfull0), .RX_I(rx0_in), .TX_O(tx0), .CTS_I(cts0), .RTS_O(rts0),
    .FRAME_ERR_O(ferr0), .PARITY_ERR_O(perr0), .OVERRUN_O(ovr0), .ERR_CLR_I(clr0));

  uart_fifo_if #(.CLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .CLK_I(clk), .RST_I(rst), .WE_I(we1), .DSEND_I(ds1), .TX_FULL_O(txfull1),
    .TX_BUSY_O(busy1), .RE_I(re1), .DREC_O(drec1), .RX_EMPTY_O(empty1),
    .RX_FULL_O(rxfull1), .RX_I(rx1_in), .TX_O(tx1), .CTS_I(cts1), .RTS_O(rts1),
    .FRAME_ERR_O(ferr1), .PARITY_ERR_O(perr1), .OVERRUN_O(ovr1), .ERR_CLR_I(clr1));

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [7:0] d);
    @(negedge clk); we0 = 1; ds0 = d;
    @(negedge clk); we0 = 0;
  endtask

  task automatic pop0();
    @(negedge clk); re0 = 1;
    @(negedge clk); re0 = 0;
  endtask

  // Drives n bits LSB first, 16 cycles each, then returns the line to idle.
  task automatic drive_frame(input int which, input logic [15:0] bits, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx0_drv = bits[i]; else rx1_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    rx0_drv = 1; rx1_drv = 1;
    cycles(4);
  endtask

  task automatic test_reset();
    rst = 1; cycles(3); rst = 0; cycles(2);
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx0: got %b expected 1", tx0); end
    checks++; if ({txfull0, busy0, empty0, rxfull0, rts0} !== 5'b00101) begin errors++; $display("FAIL reset_status0: got %b expected 00101", {txfull0, busy0, empty0, rxfull0, rts0}); end
    checks++; if ({ferr0, perr0, ovr0} !== 3'b000) begin errors++; $display("FAIL reset_err0: got %b expected 000", {ferr0, perr0, ovr0}); end
    checks++; if (drec0 !== 8'h00) begin errors++; $display("FAIL reset_drec0: got %h expected 00", drec0); end
    checks++; if ({tx1, txfull1, busy1, empty1, rxfull1, rts1, ferr1, perr1, ovr1} !== 9'b100101000) begin errors++; $display("FAIL reset_dut1: got %b expected 100101000", {tx1, txfull1, busy1, empty1, rxfull1, rts1, ferr1, perr1, ovr1}); end
  endtask

  task automatic test_loopback();
    logic [19:0] exp_bits;
    exp_bits = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    loop0 = 1;
    @(negedge clk); we0 = 1; ds0 = 8'hA5;
    @(negedge clk); ds0 = 8'h3C;
    checks++; if ({busy0, tx0} !== 2'b11) begin errors++; $display("FAIL tx_cycle1: got busy/tx %b expected 11", {busy0, tx0}); end
    @(negedge clk); we0 = 0;
    for (int t = 0; t <= 320; t++) begin
      if ((t % 16 == 8) && (t < 320)) begin
        checks++; if (tx0 !== exp_bits[t/16]) begin errors++; $display("FAIL tx_bit%0d: got %b expected %b", t/16, tx0, exp_bits[t/16]); end
      end
      if (t == 319) begin checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_end_319: got %b expected 1", busy0); end end
      if (t == 320) begin checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_end_320: got %b expected 0", busy0); end end
      @(negedge clk);
    end
    cycles(10);
    checks++; if ({empty0, drec0} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL loop_rx1: got empty %b data %h expected 0 a5", empty0, drec0); end
    pop0();
    checks++; if ({empty0, drec0} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL loop_rx2: got empty %b data %h expected 0 3c", empty0, drec0); end
    pop0();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL loop_empty: got %b expected 1", empty0); end
    checks++; if ({ferr0, perr0, ovr0} !== 3'b000) begin errors++; $display("FAIL loop_err: got %b expected 000", {ferr0, perr0, ovr0}); end
    loop0 = 0;
  endtask

  task automatic test_parity();
    logic [10:0] exp_bits;
    exp_bits = {2'b11, 1'b0, 7'h55, 1'b0};
    loop1 = 1;
    @(negedge clk); we1 = 1; ds1 = 7'h55;
    @(negedge clk); we1 = 0;
    @(negedge clk);
    for (int t = 0; t <= 176; t++) begin
      if ((t % 16 == 8) && (t < 176)) begin
        checks++; if (tx1 !== exp_bits[t/16]) begin errors++; $display("FAIL tx7e2_bit%0d: got %b expected %b", t/16, tx1, exp_bits[t/16]); end
      end
      if (t == 175) begin checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy7e2_175: got %b expected 1", busy1); end end
      if (t == 176) begin checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL busy7e2_176: got %b expected 0", busy1); end end
      @(negedge clk);
    end
    cycles(5);
    checks++; if ({empty1, drec1, perr1} !== {1'b0, 7'h55, 1'b0}) begin errors++; $display("FAIL rx7e2: got empty %b data %h perr %b expected 0 55 0", empty1, drec1, perr1); end
    @(negedge clk); re1 = 1; @(negedge clk); re1 = 0;
    loop1 = 0;
    drive_frame(1, {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
    checks++; if ({perr1, ferr1, empty1} !== 3'b101) begin errors++; $display("FAIL parity_err: got perr/ferr/empty %b expected 101", {perr1, ferr1, empty1}); end
    @(negedge clk); clr1 = 1; @(negedge clk); clr1 = 0;
    checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL parity_clr: got %b expected 0", perr1); end
  endtask

  task automatic test_frame_glitch();
    drive_frame(0, {6'b0, 1'b0, 8'h5A, 1'b0}, 10);
    checks++; if ({ferr0, perr0, empty0} !== 3'b101) begin errors++; $display("FAIL frame_err: got ferr/perr/empty %b expected 101", {ferr0, perr0, empty0}); end
    @(negedge clk); clr0 = 1; @(negedge clk); clr0 = 0;
    checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL frame_clr: got %b expected 0", ferr0); end
    @(negedge clk); rx0_drv = 0; cycles(8); rx0_drv = 1; cycles(30);
    checks++; if ({ferr0, perr0, ovr0, empty0} !== 4'b0001) begin errors++; $display("FAIL glitch: got %b expected 0001", {ferr0, perr0, ovr0, empty0}); end
    drive_frame(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
    checks++; if ({empty0, drec0, ferr0} !== {1'b0, 8'h96, 1'b0}) begin errors++; $display("FAIL after_glitch: got empty %b data %h ferr %b expected 0 96 0", empty0, drec0, ferr0); end
    pop0();
  endtask

  task automatic test_overrun();
    logic [7:0] b [5];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      drive_frame(0, {6'b0, 1'b1, b[i], 1'b0}, 10);
      checks++; if (rts0 !== (i < 1)) begin errors++; $display("FAIL rts_byte%0d: got %b expected %b", i+1, rts0, (i < 1)); end
      checks++; if (rxfull0 !== (i >= 3)) begin errors++; $display("FAIL full_byte%0d: got %b expected %b", i+1, rxfull0, (i >= 3)); end
      checks++; if (ovr0 !== (i == 4)) begin errors++; $display("FAIL ovr_byte%0d: got %b expected %b", i+1, ovr0, (i == 4)); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (drec0 !== b[i]) begin errors++; $display("FAIL ovr_data%0d: got %h expected %h", i+1, drec0, b[i]); end
      pop0();
      if (i == 1) begin checks++; if (rts0 !== 1'b0) begin errors++; $display("FAIL rts_fill2: got %b expected 0", rts0); end end
      if (i == 2) begin checks++; if (rts0 !== 1'b1) begin errors++; $display("FAIL rts_fill1: got %b expected 1", rts0); end end
    end
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL ovr_empty: got %b expected 1", empty0); end
    @(negedge clk); clr0 = 1; @(negedge clk); clr0 = 0;
  endtask

  task automatic test_cts();
    int lows;
    loop0 = 1; cts0 = 0;
    push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04);
    checks++; if (txfull0 !== 1'b1) begin errors++; $display("FAIL tx_full: got %b expected 1", txfull0); end
    push0(8'h05);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx0 !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL cts_hold: got %0d low cycles expected 0", lows); end
    cts0 = 1; cycles(40); cts0 = 0; cycles(200);
    checks++; if ({empty0, drec0} !== {1'b0, 8'h01}) begin errors++; $display("FAIL cts_frame1: got empty %b data %h expected 0 01", empty0, drec0); end
    pop0();
    checks++; if ({empty0, busy0, tx0} !== 3'b111) begin errors++; $display("FAIL cts_wait: got empty/busy/tx %b expected 111", {empty0, busy0, tx0}); end
    cts0 = 1; cycles(520);
    for (int i = 2; i <= 4; i++) begin
      checks++; if ({empty0, drec0} !== {1'b0, 8'(i)}) begin errors++; $display("FAIL cts_frame%0d: got empty %b data %h expected 0 %h", i, empty0, drec0, 8'(i)); end
      pop0();
    end
    checks++; if ({empty0, busy0, txfull0} !== 3'b100) begin errors++; $display("FAIL cts_done: got empty/busy/full %b expected 100", {empty0, busy0, txfull0}); end
    loop0 = 0;
  endtask

  task automatic test_reset_midframe();
    loop0 = 1;
    push0(8'h5A);
    cycles(50);
    rst = 1; #1;
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL rst_tx_async: got %b expected 1", tx0); end
    checks++; if ({txfull0, busy0, empty0, rxfull0, rts0, ferr0, perr0, ovr0, drec0} !== {8'b00101000, 8'h00}) begin errors++; $display("FAIL rst_outputs: got %b expected 0010100000000000", {txfull0, busy0, empty0, rxfull0, rts0, ferr0, perr0, ovr0, drec0}); end
    @(negedge clk); rst = 0;
    push0(8'hC3);
    cycles(200);
    checks++; if ({empty0, drec0, ferr0, perr0} !== {1'b0, 8'hC3, 2'b00}) begin errors++; $display("FAIL rst_next_frame: got empty %b data %h err %b expected 0 c3 00", empty0, drec0, {ferr0, perr0}); end
    pop0();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rst_next_empty: got %b expected 1", empty0); end
    loop0 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_parity();
    test_frame_glitch();
    test_overrun();
    test_cts();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_if.md
# uart_fifo_if

Parametrised UART interface: transmitter, oversampled receiver, and a FIFO on each direction, with configurable data bits, parity, stop bits and FIFO depth. It adds CTS/RTS hardware flow control and sticky frame, parity and overrun error flags. It sits between the debug-transport logic and the board pins, where it replaces the fixed 8N1 interface. Its byte-side handshake is the same WE/RE FIFO style as that interface.

## Interface
- CLK_RATE, 100000000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate. DIV = CLK_RATE/BAUD_RATE, truncated. DIV must be ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits sent, 1 or 2. The receiver checks only the first.
- FIFO_DEPTH, 16: entries per FIFO. Power of two, ≥ 4.

Ports:
- CLK_I  in  1  single clock.
- RST_I  in  1  asynchronous reset, active-high.
- WE_I  in  1  push DSEND_I into the TX FIFO.
- DSEND_I  in  DATA_BITS  transmit data.
- TX_FULL_O  out  1  TX FIFO full.
- TX_BUSY_O  out  1  TX FIFO non-empty or a frame is in progress.
- RE_I  in  1  pop the RX FIFO head.
- DREC_O  out  DATA_BITS  RX FIFO head (first-word fall-through).
- RX_EMPTY_O  out  1  RX FIFO empty.
- RX_FULL_O  out  1  RX FIFO full.
- RX_I  in  1  serial input (asynchronous).
- TX_O  out  1  serial output.
- CTS_I  in  1  high = peer allows transmission.
- RTS_O  out  1  high = we accept data. Low when RX fill ≥ FIFO_DEPTH/2.
- FRAME_ERR_O, PARITY_ERR_O, OVERRUN_O  out  1 each  sticky error flags.
- ERR_CLR_I  in  1  clears all three error flags.

## Operation
**Frame format**
- Idle-high line. Order: start (0), data LSB first, optional parity, stop bit(s) (1).
- Each bit lasts DIV cycles.

**TX FSM (IDLE → START → DATA → PARITY → STOP → IDLE)**
- PARITY is skipped when PARITY = 0.
- STOP lasts STOP_BITS × DIV cycles.
- IDLE leaves only when the TX FIFO is non-empty and CTS_I = 1. The FIFO pops on that transition.
- CTS_I is sampled only in IDLE. A started frame always completes.
- After STOP the FSM goes straight to START when data is pending and CTS_I is high, giving back-to-back frames with no idle bit.
- WE_I while TX_FULL_O is high: ignored, with no flag raised.

**RX input and FSM (IDLE → START → DATA → PARITY → STOP → IDLE)**
- RX_I passes through a 2-flop synchroniser.
- IDLE detects a falling edge, then samples at DIV/2 cycles.
  - Sample still 0: continue.
  - Sample 1: glitch; return to IDLE with no flag.
- Later bits are sampled every DIV cycles, at bit centre.
- The FSM returns to IDLE right after the stop-bit sample, for resynchronisation.

**Received-byte outcome**
- Stop sample 0: FRAME_ERR_O set, byte discarded.
- Parity mismatch (stop bit good): PARITY_ERR_O set, byte discarded.
- Good byte with the RX FIFO full and no RE_I that cycle: OVERRUN_O set, byte dropped.
- Good byte with the RX FIFO full and RE_I the same cycle: push and pop both succeed, count unchanged.
- RE_I while empty: ignored. DREC_O is don't-care while empty.

**FIFOs and flags**
- Count width is log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Flags are registered and update in the cycle after the push/pop edge.
- Error flags are sticky. Set has priority over ERR_CLR_I in the same cycle.

**Reset values**
- TX_O = 1 (asynchronously, including mid-frame). Both FSMs in IDLE.
- Both FIFOs empty: TX_FULL_O = 0, TX_BUSY_O = 0, RX_EMPTY_O = 1, RX_FULL_O = 0.
- RTS_O = 1. All error flags 0. DREC_O = 0.
- Reset mid-frame aborts the frame and discards partial data.

## Timing
- WE_I in cycle 0, TX idle, CTS_I high: TX_O low from cycle 2. TX_BUSY_O high from cycle 1.
- TX frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- RX: RX_EMPTY_O falls at most 2 cycles after the stop-bit centre sample. Worst-case start detection adds 2 synchroniser cycles.
- RE_I in cycle n: DREC_O shows the next entry in cycle n+1.
- RTS_O updates one cycle after the fill count crosses FIFO_DEPTH/2 in either direction.
- The receiver tolerates ±2% baud mismatch at DIV ≥ 16.

## Test plan
Common setup: CLK_RATE = 16, BAUD_RATE = 1 (DIV = 16).

1. 8N1, write 0xA5 then 0x3C, with TX_O looped to RX_I.
   - TX_O shows start, 1,0,1,0,0,1,0,1, stop.
   - Frames are back-to-back: 320 cycles total.
   - DREC_O reads 0xA5 then 0x3C. No error flags.
2. DATA_BITS = 7, PARITY = 2 (even), STOP_BITS = 2, write 0x55.
   - Parity bit 0. Frame is 11 bits = 176 cycles.
   - Inject the same frame with parity 1 on RX_I: PARITY_ERR_O = 1, RX FIFO stays empty.
   - ERR_CLR_I clears the flag.
3. Drive a stop bit of 0 on RX_I: FRAME_ERR_O = 1, byte discarded.
   - Drive an 8-cycle low pulse on RX_I: no flag, receiver back in IDLE.
4. FIFO_DEPTH = 4, receive 5 bytes without RE_I.
   - RTS_O falls after byte 2. RX_FULL_O after byte 4.
   - Byte 5: OVERRUN_O = 1. Contents are bytes 1–4 in order.
5. Hold CTS_I = 0 and write 3 bytes: TX_O stays 1.
   - Raise CTS_I: 3 frames sent.
   - Drop CTS_I mid-frame 1: frame 1 completes, frame 2 waits.
6. Assert RST_I mid-TX-frame and mid-RX-frame.
   - TX_O = 1 immediately. All outputs at reset values.
   - The next frame is received correctly.
